riscv_dmem_responder: RTL and testbench

Responder (slave) end of the CPU data-memory interface, for a multicycle or pipelined core that issues request/ready transactions instead of single-cycle combinational accesses.
Holds a word-organised data array and accepts one read or write per transaction.
Inserts a programmable number of wait states, applies byte-lane selects on writes and reads, and flags out-of-range accesses.
Sits between riscv_cpu's dmem port and the memory array; the bench drives the requester side.

---
 rtl/riscv_dmem_responder_if.sv | 26 ++
 rtl/riscv_dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_riscv_dmem_responder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_responder_if.sv
// Data-memory request/ready bus between a CPU (master) and the memory responder (slave).
// Requester drives: i_dmem_req, i_dmem_wr_en, i_dmem_addr, i_dmem_byte_sel, i_dmem_wr_data.
// Responder drives: o_dmem_ready, o_dmem_rd_data, o_dmem_err, o_dmem_busy.
interface riscv_dmem_responder_if #(
    parameter int unsigned XLEN = 32
);
    logic                  i_dmem_req;
    logic                  i_dmem_wr_en;
    logic [XLEN-1:0]       i_dmem_addr;
    logic [XLEN/8-1:0]     i_dmem_byte_sel;
    logic [XLEN-1:0]       i_dmem_wr_data;
    logic                  o_dmem_ready;
    logic [XLEN-1:0]       o_dmem_rd_data;
    logic                  o_dmem_err;
    logic                  o_dmem_busy;

    modport master (
        output i_dmem_req, i_dmem_wr_en, i_dmem_addr, i_dmem_byte_sel, i_dmem_wr_data,
        input  o_dmem_ready, o_dmem_rd_data, o_dmem_err, o_dmem_busy
    );

    modport slave (
        input  i_dmem_req, i_dmem_wr_en, i_dmem_addr, i_dmem_byte_sel, i_dmem_wr_data,
        output o_dmem_ready, o_dmem_rd_data, o_dmem_err, o_dmem_busy
    );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Responder end of the CPU data-memory bus: word-organised array, one read or write per
// transaction, LATENCY wait states, byte-lane selects and out-of-range error reporting.
// Ports:
//   i_clk  - clock, all state changes on the rising edge
//   i_rstn - asynchronous active-low reset (array contents are preserved)
//   dmem   - slave side of riscv_dmem_responder_if (request in, ready/data/err/busy out)
module riscv_dmem_responder #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned DMEM_ADDR_BIT = 12,
    parameter int unsigned LATENCY       = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    riscv_dmem_responder_if.slave dmem
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned LANES = XLEN / 8;
    localparam int unsigned IDX_W = DMEM_ADDR_BIT - 2;
    localparam int unsigned DEPTH = 2 ** IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    // captured request
    logic               req_wr_en;
    logic [XLEN-1:0]    req_addr;
    logic [LANES-1:0]   req_byte_sel;
    logic [XLEN-1:0]    req_wr_data;

    // request as seen by the commit logic
    logic               sel_wr_en;
    logic [XLEN-1:0]    sel_addr;
    logic [LANES-1:0]   sel_byte_sel;
    logic [XLEN-1:0]    sel_wr_data;
    logic               unused_addr_lsb;

    logic               range_err;
    logic               txn_err;
    logic [IDX_W-1:0]   word_idx;
    logic [XLEN-1:0]    word_old;
    logic [XLEN-1:0]    word_merged;
    logic [XLEN-1:0]    word_masked;

    logic               commit;
    logic               mem_we;
    logic               ready_nxt;
    logic               err_nxt;
    logic               busy_nxt;
    logic [XLEN-1:0]    rd_data_nxt;

    logic               ready_q;
    logic               err_q;
    logic               busy_q;
    logic [XLEN-1:0]    rd_data_q;

    logic [XLEN-1:0]    mem [DEPTH];

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dmem.i_dmem_req) state_nxt = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY=0 the commit happens on the accept edge, before capture, so the
    // commit logic reads the live bus while IDLE and the captured copy otherwise.
    assign sel_wr_en       = (state == IDLE) ? dmem.i_dmem_wr_en    : req_wr_en;
    assign sel_addr        = (state == IDLE) ? dmem.i_dmem_addr     : req_addr;
    assign sel_byte_sel    = (state == IDLE) ? dmem.i_dmem_byte_sel : req_byte_sel;
    assign sel_wr_data     = (state == IDLE) ? dmem.i_dmem_wr_data  : req_wr_data;
    assign unused_addr_lsb = ^sel_addr[1:0];

    assign range_err = (sel_addr[XLEN-1:DMEM_ADDR_BIT] != '0);
    assign txn_err   = range_err || (sel_wr_en && (sel_byte_sel == '0));
    assign word_idx  = sel_addr[DMEM_ADDR_BIT-1:2];
    assign word_old  = mem[word_idx];

    // Byte-lane merge for writes and lane masking for reads
    always_comb begin
        word_merged = word_old;
        word_masked = '0;
        for (int unsigned n = 0; n < LANES; n++) begin
            if (sel_byte_sel[n]) begin
                word_merged[8*n +: 8] = sel_wr_data[8*n +: 8];
                word_masked[8*n +: 8] = word_old[8*n +: 8];
            end
        end
    end

    // Output / datapath next values
    always_comb begin
        commit      = (state_nxt == RESP);
        cnt_nxt     = cnt;
        ready_nxt   = commit;
        err_nxt     = commit && txn_err;
        busy_nxt    = (state_nxt != IDLE);
        rd_data_nxt = rd_data_q;
        mem_we      = 1'b0;
        case (state)
            IDLE:    if (dmem.i_dmem_req) cnt_nxt = CNT_W'(LATENCY);
            WAIT:    cnt_nxt = cnt - CNT_W'(1);
            default: cnt_nxt = cnt;
        endcase
        if (commit) begin
            if (txn_err) begin
                rd_data_nxt = '0;
            end else if (sel_wr_en) begin
                // a clock edge while reset is held must not commit a write
                mem_we = i_rstn;
            end else begin
                rd_data_nxt = word_masked;
            end
        end
    end

    // Counter, request capture and registered outputs
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt          <= '0;
            req_wr_en    <= 1'b0;
            req_addr     <= '0;
            req_byte_sel <= '0;
            req_wr_data  <= '0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            cnt       <= cnt_nxt;
            ready_q   <= ready_nxt;
            err_q     <= err_nxt;
            busy_q    <= busy_nxt;
            rd_data_q <= rd_data_nxt;
            if ((state == IDLE) && dmem.i_dmem_req) begin
                req_wr_en    <= dmem.i_dmem_wr_en;
                req_addr     <= dmem.i_dmem_addr;
                req_byte_sel <= dmem.i_dmem_byte_sel;
                req_wr_data  <= dmem.i_dmem_wr_data;
            end
        end
    end

    // Data array, not reset
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[word_idx] <= word_merged;
        end
    end

    assign dmem.o_dmem_ready   = ready_q;
    assign dmem.o_dmem_err     = err_q;
    assign dmem.o_dmem_busy    = busy_q;
    assign dmem.o_dmem_rd_data = rd_data_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder: one instance with LATENCY=2 (index 0) and one with
// LATENCY=0 (index 1). A transaction-level model predicts ready/err/busy/rd_data every
// cycle; directed sequences add hand-computed literal expectations.
module tb_riscv_dmem_responder;

    logic clk;
    logic rstn;

    logic        req   [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [3:0]  sel   [2];
    logic [31:0] wdata [2];
    logic        ready [2];
    logic        err   [2];
    logic        busy  [2];
    logic [31:0] rdata [2];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    riscv_dmem_responder_if #(.XLEN(32)) if_l2 ();
    riscv_dmem_responder_if #(.XLEN(32)) if_l0 ();

    assign if_l2.i_dmem_req      = req[0];
    assign if_l2.i_dmem_wr_en    = wr[0];
    assign if_l2.i_dmem_addr     = addr[0];
    assign if_l2.i_dmem_byte_sel = sel[0];
    assign if_l2.i_dmem_wr_data  = wdata[0];
    assign ready[0] = if_l2.o_dmem_ready;
    assign err[0]   = if_l2.o_dmem_err;
    assign busy[0]  = if_l2.o_dmem_busy;
    assign rdata[0] = if_l2.o_dmem_rd_data;

    assign if_l0.i_dmem_req      = req[1];
    assign if_l0.i_dmem_wr_en    = wr[1];
    assign if_l0.i_dmem_addr     = addr[1];
    assign if_l0.i_dmem_byte_sel = sel[1];
    assign if_l0.i_dmem_wr_data  = wdata[1];
    assign ready[1] = if_l0.o_dmem_ready;
    assign err[1]   = if_l0.o_dmem_err;
    assign busy[1]  = if_l0.o_dmem_busy;
    assign rdata[1] = if_l0.o_dmem_rd_data;

    riscv_dmem_responder #(.XLEN(32), .DMEM_ADDR_BIT(12), .LATENCY(2)) u_dut_l2 (
        .i_clk  (clk),
        .i_rstn (rstn),
        .dmem   (if_l2)
    );

    riscv_dmem_responder #(.XLEN(32), .DMEM_ADDR_BIT(12), .LATENCY(0)) u_dut_l0 (
        .i_clk  (clk),
        .i_rstn (rstn),
        .dmem   (if_l0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          m_lat [2] = '{2, 0};
    logic        m_pend  [2];
    int          m_at    [2];
    logic        m_wr    [2];
    logic [31:0] m_addr  [2];
    logic [3:0]  m_sel   [2];
    logic [31:0] m_wdata [2];
    logic        m_ready [2];
    logic        m_err   [2];
    logic [31:0] m_rd    [2];
    logic [31:0] m_mem   [2][1024];

    // One clock edge of the model: accept when free, respond LATENCY edges after accept,
    // and stay unavailable during the response cycle.
    task automatic model_step(input int d);
        logic        was_resp;
        logic [31:0] mask;
        logic [31:0] old;
        if (!rstn) begin
            m_pend[d]  = 1'b0;
            m_ready[d] = 1'b0;
            m_err[d]   = 1'b0;
            m_rd[d]    = 32'h0;
            return;
        end
        was_resp   = m_ready[d];
        m_ready[d] = 1'b0;
        m_err[d]   = 1'b0;
        if (!m_pend[d] && !was_resp && req[d]) begin
            m_pend[d]  = 1'b1;
            m_at[d]    = cyc + m_lat[d];
            m_wr[d]    = wr[d];
            m_addr[d]  = addr[d];
            m_sel[d]   = sel[d];
            m_wdata[d] = wdata[d];
        end
        if (m_pend[d] && cyc == m_at[d]) begin
            m_pend[d]  = 1'b0;
            m_ready[d] = 1'b1;
            mask = {{8{m_sel[d][3]}}, {8{m_sel[d][2]}}, {8{m_sel[d][1]}}, {8{m_sel[d][0]}}};
            if (m_addr[d] >= 32'h1000 || (m_wr[d] && m_sel[d] == 4'b0000)) begin
                m_err[d] = 1'b1;
                m_rd[d]  = 32'h0;
            end else begin
                old = m_mem[d][m_addr[d][11:2]];
                if (m_wr[d]) m_mem[d][m_addr[d][11:2]] = (old & ~mask) | (m_wdata[d] & mask);
                else         m_rd[d] = old & mask;
            end
        end
    endtask

    // Model update on every rising edge, comparison 2 ns later
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) model_step(d);
            #2;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("ready dut%0d cyc%0d", d, cyc), 32'(ready[d]), 32'(m_ready[d]));
                check($sformatf("err dut%0d cyc%0d", d, cyc), 32'(err[d]), 32'(m_err[d]));
                check($sformatf("busy dut%0d cyc%0d", d, cyc), 32'(busy[d]), 32'(m_pend[d] || m_ready[d]));
                check($sformatf("rd_data dut%0d cyc%0d", d, cyc), rdata[d], m_rd[d]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Issue one transaction from a negedge; returns data/err at the ready cycle and the
    // number of cycles from the accept edge to the ready-high cycle.
    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e,
                       output int lat);
        @(negedge clk);
        req[d] = 1'b1; wr[d] = w; addr[d] = a; sel[d] = s; wdata[d] = wd;
        @(negedge clk);
        // bus is don't-care after the accept edge
        req[d] = 1'b0; wr[d] = 1'($urandom); addr[d] = $urandom;
        sel[d] = 4'($urandom); wdata[d] = $urandom;
        lat = 1;
        while (ready[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("ready seen dut%0d addr %h", d, a), 32'(ready[d]), 32'h1);
        rd = rdata[d];
        e  = err[d];
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;
    int          pulses;
    logic [31:0] got [8];

    initial begin
        rstn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; sel[d] = '0; wdata[d] = '0;
        end

        // reset then idle
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        check("idle ready", 32'(ready[0]), 32'h0);
        check("idle busy", 32'(busy[0]), 32'h0);
        check("idle err", 32'(err[0]), 32'h0);
        check("idle rd_data", rdata[0], 32'h0);

        // basic write/read with LATENCY=2
        txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, e, lat);
        check("wr latency", 32'(lat), 32'd3);
        check("wr err", 32'(e), 32'h0);
        txn(0, 1'b0, 32'h10, 4'hF, 32'h0, rd, e, lat);
        check("rd latency", 32'(lat), 32'd3);
        check("rd data 0x10", rd, 32'hDEADBEEF);
        check("rd err", 32'(e), 32'h0);

        // byte lanes
        txn(0, 1'b1, 32'h20, 4'b1111, 32'h11223344, rd, e, lat);
        txn(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, rd, e, lat);
        txn(0, 1'b0, 32'h20, 4'b1111, 32'h0, rd, e, lat);
        check("lane merge", rd, 32'h11BB33DD);
        txn(0, 1'b0, 32'h20, 4'b0010, 32'h0, rd, e, lat);
        check("lane mask", rd, 32'h00003300);
        txn(0, 1'b0, 32'h23, 4'b0000, 32'h0, rd, e, lat);
        check("rd sel0 data", rd, 32'h0);
        check("rd sel0 err", 32'(e), 32'h0);

        // errors: out of range (aliases word 0 if truncated) and write with no lanes
        txn(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, rd, e, lat);
        txn(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, rd, e, lat);
        check("range err", 32'(e), 32'h1);
        check("range rd_data", rd, 32'h0);
        txn(0, 1'b0, 32'h0, 4'hF, 32'h0, rd, e, lat);
        check("array kept after range err", rd, 32'hCAFEF00D);
        txn(0, 1'b1, 32'h0, 4'b0000, 32'h12121212, rd, e, lat);
        check("sel0 write err", 32'(e), 32'h1);
        txn(0, 1'b0, 32'h0, 4'hF, 32'h0, rd, e, lat);
        check("array kept after sel0 err", rd, 32'hCAFEF00D);

        // reset during WAIT drops the pending write
        txn(0, 1'b1, 32'h30, 4'hF, 32'h0BADF00D, rd, e, lat);
        txn(0, 1'b0, 32'h30, 4'hF, 32'h0, rd, e, lat);
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h30; sel[0] = 4'hF; wdata[0] = 32'h12345678;
        @(negedge clk);
        req[0] = 1'b0;
        check("busy before abort", 32'(busy[0]), 32'h1);
        #2 rstn = 1'b0;
        #1;
        check("abort busy", 32'(busy[0]), 32'h0);
        check("abort ready", 32'(ready[0]), 32'h0);
        check("abort rd_data", rdata[0], 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        txn(0, 1'b0, 32'h30, 4'hF, 32'h0, rd, e, lat);
        check("aborted write not committed", rd, 32'h0BADF00D);

        // LATENCY=0: preload, then hold req high for 6 cycles
        txn(1, 1'b1, 32'h40, 4'hF, 32'hA0A0A0A0, rd, e, lat);
        check("l0 latency", 32'(lat), 32'd1);
        txn(1, 1'b1, 32'h44, 4'hF, 32'hB1B1B1B1, rd, e, lat);
        txn(1, 1'b1, 32'h48, 4'hF, 32'hC2C2C2C2, rd, e, lat);
        @(negedge clk);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0 && ready[1] === 1'b1) begin
                got[pulses] = rdata[1];
                pulses++;
            end
            if (i < 6) begin
                req[1] = 1'b1; wr[1] = 1'b0; sel[1] = 4'hF;
                addr[1] = (i % 2 == 0) ? 32'h40 + 32'(4 * (i / 2)) : 32'h4C;
            end else begin
                req[1] = 1'b0;
            end
            @(negedge clk);
        end
        check("l0 pulse count", 32'(pulses), 32'd3);
        check("l0 rd 0", got[0], 32'hA0A0A0A0);
        check("l0 rd 1", got[1], 32'hB1B1B1B1);
        check("l0 rd 2", got[2], 32'hC2C2C2C2);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
